// File: rtl/store_merge_unit.sv
// rtl/store_merge_unit.sv - store lane narrowing and merge into a word-wide data memory
//
// Purpose:
//   Accepts sw/sh/sb store requests from EX/MEM, narrows the register data to
//   the addressed byte/halfword lane and writes it to a word-addressed data
//   memory. Without byte-enable support, sh/sb use read-modify-write.
//
// Configuration:
//   STORE_MERGE_BE_EN - memory honours mem_be; sh/sb skip the read and write
//                       lane-replicated data with the lane mask in mem_be.
//
// Ports:
//   clk, reset              clock, synchronous active-low reset
//   req_valid/req_ready     store request handshake (ready only in IDLE)
//   st_op, addr, wdata      00=sw 01=sh 10=sb 11=reserved, byte address, rt data
//   done, err               one-cycle completion pulse, reject flag with done
//   mem_req/mem_ack         memory access handshake (ack may be same cycle)
//   mem_we, mem_addr        write/read select, word address
//   mem_wdata, mem_be       write data, per-lane byte enables
//   mem_rdata               read data, valid with mem_ack on a read

module store_merge_unit #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        st_op,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              done,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam logic [1:0] OP_SW = 2'b00;
    localparam logic [1:0] OP_SH = 2'b01;
    localparam logic [1:0] OP_SB = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rej_q, rej_d;

    // Address bits above the memory range do not select anything.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[31:ADDR_W+2];

    logic        illegal;
    logic [3:0]  lane_be;
    logic [31:0] lane_mask;
    logic [31:0] rep_data;

    assign illegal = (st_op == 2'b11)
                  || ((st_op == OP_SW) && (addr[1:0] != 2'b00))
                  || ((st_op == OP_SH) && addr[0]);

    // Lane enables and lane-replicated data derived from the latched request.
    always_comb begin
        lane_be  = 4'b1111;
        rep_data = wdata_q;
        case (op_q)
            OP_SH: begin
                lane_be  = addr_q[1] ? 4'b1100 : 4'b0011;
                rep_data = {2{wdata_q[15:0]}};
            end
            OP_SB: begin
                lane_be  = 4'b0001 << addr_q[1:0];
                rep_data = {4{wdata_q[7:0]}};
            end
            default: begin
                lane_be  = 4'b1111;
                rep_data = wdata_q;
            end
        endcase
    end

    assign lane_mask = {{8{lane_be[3]}}, {8{lane_be[2]}}, {8{lane_be[1]}}, {8{lane_be[0]}}};

`ifdef STORE_MERGE_BE_EN
    logic [31:0] write_word;
    logic        unused_rdata;
    assign write_word   = rep_data;
    assign unused_rdata = ^mem_rdata;
`else
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] write_word;
    // Enabled lanes take the new data, all others keep the word read back.
    assign write_word = (rep_data & lane_mask) | (rdata_q & ~lane_mask);
`endif

    assign mem_addr = addr_q[ADDR_W+1:2];

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rej_d     = rej_q;
`ifndef STORE_MERGE_BE_EN
        rdata_d   = rdata_q;
`endif
        req_ready = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_wdata = 32'h0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_d    = st_op;
                    addr_d  = addr[ADDR_W+1:0];
                    wdata_d = wdata;
                    rej_d   = illegal;
                    if (illegal) begin
                        state_d = S_RESP;
                    end else if (st_op == OP_SW) begin
                        state_d = S_WRITE;
                    end else begin
`ifdef STORE_MERGE_BE_EN
                        state_d = S_WRITE;
`else
                        state_d = S_READ;
`endif
                    end
                end
            end
            S_READ: begin
                mem_req = 1'b1;
                if (mem_ack) begin
`ifndef STORE_MERGE_BE_EN
                    rdata_d = mem_rdata;
`endif
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_be    = lane_be;
                mem_wdata = write_word;
                if (mem_ack) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                done    = 1'b1;
                err     = rej_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= 2'b00;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rej_q   <= 1'b0;
`ifndef STORE_MERGE_BE_EN
            rdata_q <= 32'h0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rej_q   <= rej_d;
`ifndef STORE_MERGE_BE_EN
            rdata_q <= rdata_d;
`endif
        end
    end

endmodule

// File: tb/tb_store_merge_unit.sv
// tb/tb_store_merge_unit.sv - directed self-checking bench for store_merge_unit

module tb_store_merge_unit;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        st_op;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              done;
    logic              err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    store_merge_unit #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .st_op     (st_op),
        .addr      (addr),
        .wdata     (wdata),
        .done      (done),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    // Memory model
    logic [31:0] mem [0:1023];
    int          wait_cfg;
    bit          ack_block;
    int          wait_cnt;
    bit          poke_req;
    logic [9:0]  poke_addr;
    logic [31:0] poke_data;
    int          wr_cnt;
    int          rd_cnt;
    logic [9:0]  last_wa;
    logic [31:0] last_wd;
    logic [3:0]  last_be;

    assign mem_ack   = mem_req && !ack_block && (wait_cnt >= wait_cfg);
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (!reset || !mem_req || mem_ack) wait_cnt <= 0;
        else                               wait_cnt <= wait_cnt + 1;
        if (poke_req) mem[poke_addr] <= poke_data;
        if (mem_req && mem_ack) begin
            if (mem_we) begin
                wr_cnt  <= wr_cnt + 1;
                last_wa <= mem_addr;
                last_wd <= mem_wdata;
                last_be <= mem_be;
`ifdef STORE_MERGE_BE_EN
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
`else
                mem[mem_addr] <= mem_wdata;
`endif
            end else begin
                rd_cnt <= rd_cnt + 1;
            end
        end
    end

    // Request-stability and request-cycle monitor
    int          req_cycles;
    int          stab_err;
    bit          pend_q;
    logic [46:0] snap;

    always @(negedge clk) begin
        if (mem_req) req_cycles <= req_cycles + 1;
        if (pend_q && mem_req && ({mem_we, mem_addr, mem_wdata, mem_be} !== snap))
            stab_err <= stab_err + 1;
        pend_q <= mem_req && !mem_ack;
        snap   <= {mem_we, mem_addr, mem_wdata, mem_be};
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [9:0] a, input logic [31:0] d);
        poke_req  = 1'b1;
        poke_addr = a;
        poke_data = d;
        @(posedge clk); #1;
        poke_req  = 1'b0;
    endtask

    // Issues one request and returns the cycle index (relative to the accept
    // edge) at which done was seen; 0 means it never came.
    task automatic do_store(input string tag, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] d, input int exp_lat, input bit exp_err);
        int  k;
        bit  seen;
        logic e;
        k = 0;
        seen = 1'b0;
        e = 1'b0;
        check_eq({tag, ".ready"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        st_op = op;
        addr = a;
        wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                k = i;
                e = err;
            end else begin
                @(posedge clk); #1;
            end
        end
        check_eq({tag, ".done_lat"}, k, exp_lat);
        check_eq({tag, ".err"}, {31'b0, e}, {31'b0, exp_err});
        @(posedge clk); #1;
    endtask

    int wr0, rd0, rq0;

    initial begin
        reset = 1'b0;
        req_valid = 1'b0;
        st_op = 2'b00;
        addr = 32'h0;
        wdata = 32'h0;
        wait_cfg = 0;
        ack_block = 1'b0;
        wait_cnt = 0;
        poke_req = 1'b0;
        poke_addr = '0;
        poke_data = '0;
        wr_cnt = 0;
        rd_cnt = 0;
        last_wa = '0;
        last_wd = '0;
        last_be = '0;
        req_cycles = 0;
        stab_err = 0;
        pend_q = 1'b0;
        snap = '0;

        // Initial reset
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_eq("rst.ready", {31'b0, req_ready}, 32'd1);
        check_eq("rst.mem_req", {31'b0, mem_req}, 32'd0);
        check_eq("rst.done", {31'b0, done}, 32'd0);
        check_eq("rst.err", {31'b0, err}, 32'd0);
        check_eq("rst.mem_be", {28'b0, mem_be}, 32'd0);
        check_eq("rst.mem_wdata", mem_wdata, 32'd0);
        check_eq("rst.mem_addr", {22'b0, mem_addr}, 32'd0);
        @(posedge clk); #1;

        // Reset while stalled in WRITE
        poke(10'd5, 32'h0000_0055);
        ack_block = 1'b1;
        req_valid = 1'b1;
        st_op = 2'b00;
        addr = 32'h0000_0014;
        wdata = 32'h0000_0099;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("rstw.in_write", {30'b0, mem_req, mem_we}, 32'd3);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_eq("rstw.mem_req", {31'b0, mem_req}, 32'd0);
        check_eq("rstw.done", {31'b0, done}, 32'd0);
        check_eq("rstw.ready", {31'b0, req_ready}, 32'd1);
        ack_block = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rstw.no_late_req", {31'b0, mem_req}, 32'd0);
        check_eq("rstw.word5", mem[5], 32'h0000_0055);
        @(posedge clk); #1;

        // sw, zero wait
        wr0 = wr_cnt;
        do_store("sw", 2'b00, 32'h0000_0008, 32'hDEADBEEF, 2, 1'b0);
        check_eq("sw.writes", wr_cnt - wr0, 32'd1);
        check_eq("sw.addr", {22'b0, last_wa}, 32'd2);
        check_eq("sw.wdata", last_wd, 32'hDEADBEEF);
        check_eq("sw.be", {28'b0, last_be}, 32'hF);
        check_eq("sw.mem2", mem[2], 32'hDEADBEEF);

        // sb into lane 2
        poke(10'd3, 32'h1122_3344);
        wr0 = wr_cnt;
        rd0 = rd_cnt;
`ifdef STORE_MERGE_BE_EN
        do_store("sb", 2'b10, 32'h0000_000E, 32'hFFFFFFAB, 2, 1'b0);
        check_eq("sb.reads", rd_cnt - rd0, 32'd0);
        check_eq("sb.wdata", last_wd, 32'hABABABAB);
`else
        do_store("sb", 2'b10, 32'h0000_000E, 32'hFFFFFFAB, 3, 1'b0);
        check_eq("sb.reads", rd_cnt - rd0, 32'd1);
        check_eq("sb.wdata", last_wd, 32'h11AB3344);
`endif
        check_eq("sb.writes", wr_cnt - wr0, 32'd1);
        check_eq("sb.addr", {22'b0, last_wa}, 32'd3);
        check_eq("sb.be", {28'b0, last_be}, 32'h4);
        check_eq("sb.mem3", mem[3], 32'h11AB3344);

        // sh high half, two wait cycles per access
        poke(10'd0, 32'hAAAA_5555);
        wait_cfg = 2;
        wr0 = wr_cnt;
`ifdef STORE_MERGE_BE_EN
        do_store("sh", 2'b01, 32'h0000_0002, 32'h0000_1234, 4, 1'b0);
        check_eq("sh.wdata", last_wd, 32'h12341234);
`else
        do_store("sh", 2'b01, 32'h0000_0002, 32'h0000_1234, 7, 1'b0);
        check_eq("sh.wdata", last_wd, 32'h12345555);
`endif
        check_eq("sh.writes", wr_cnt - wr0, 32'd1);
        check_eq("sh.be", {28'b0, last_be}, 32'hC);
        check_eq("sh.mem0", mem[0], 32'h12345555);
        check_eq("sh.stable", stab_err, 32'd0);
        wait_cfg = 0;

        // Rejected requests
        rq0 = req_cycles;
        wr0 = wr_cnt;
        do_store("mis_sw", 2'b00, 32'h0000_0005, 32'h1, 1, 1'b1);
        do_store("mis_sh", 2'b01, 32'h0000_0003, 32'h2, 1, 1'b1);
        do_store("rsv_op", 2'b11, 32'h0000_0000, 32'h3, 1, 1'b1);
        check_eq("rej.no_req", req_cycles - rq0, 32'd0);
        check_eq("rej.no_write", wr_cnt - wr0, 32'd0);

        // Back-to-back sw with req_valid held high
        check_eq("b2b.ready0", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        st_op = 2'b00;
        addr = 32'h0000_0010;
        wdata = 32'h0000_0001;
        @(posedge clk); #1;
        addr = 32'h0000_0014;
        wdata = 32'h0000_0002;
        @(negedge clk);
        check_eq("b2b.w1_ready", {31'b0, req_ready}, 32'd0);
        check_eq("b2b.w1_addr", {22'b0, mem_addr}, 32'd4);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("b2b.r1_done", {31'b0, done}, 32'd1);
        check_eq("b2b.r1_ready", {31'b0, req_ready}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("b2b.idle_ready", {31'b0, req_ready}, 32'd1);
        check_eq("b2b.idle_done", {31'b0, done}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("b2b.w2_req", {31'b0, mem_req}, 32'd1);
        check_eq("b2b.w2_addr", {22'b0, mem_addr}, 32'd5);
        check_eq("b2b.w2_ready", {31'b0, req_ready}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("b2b.r2_done", {31'b0, done}, 32'd1);
        @(posedge clk); #1;
        check_eq("b2b.mem4", mem[4], 32'h0000_0001);
        check_eq("b2b.mem5", mem[5], 32'h0000_0002);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/store_merge_unit.md
Name: store_merge_unit

Overview:
- Store-side counterpart of the immediate/load extension path.
- Takes a CPU store request (sw/sh/sb), narrows the register data to the addressed byte or halfword lane, and merges it into a word-wide data memory.
- Without byte-enable support, sh/sb are done as a read-modify-write sequence.
- Sits between the EX/MEM stage and the word-addressed DM.

Parameters:
- ADDR_W, 10, word-address width of the data memory (1024 words); the memory word address is addr[ADDR_W+1:2].

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  store request valid
- req_ready  out  1  unit can accept a request; high only in IDLE
- st_op  in  2  00=sw, 01=sh, 10=sb, 11=reserved
- addr  in  32  byte address
- wdata  in  32  register data (rt)
- done  out  1  one-cycle pulse: store finished or rejected
- err  out  1  one-cycle pulse with done: misaligned or reserved op, no memory write
- mem_req  out  1  memory access request, held until mem_ack
- mem_we  out  1  1=write, 0=read
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  write data
- mem_be  out  4  byte enables; lane k = bits 8k+7:8k
- mem_rdata  in  32  read data, valid in the cycle mem_ack=1 on a read
- mem_ack  in  1  access complete; may be asserted in the same cycle as mem_req

Behaviour:
- Reset (reset=0 at a clk edge):
  - state goes to IDLE.
  - done, err, mem_req, mem_we are 0; mem_addr, mem_wdata, latched regs are 0; mem_be=0.
  - Any in-flight store is dropped and no further memory access is made for it.
  - req_ready=1 from the first cycle after reset is released.
- Accept: req_valid && req_ready at an edge latches st_op, addr, wdata. Inputs are ignored in all other states.
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - On accept with a legal, aligned op: sw goes to WRITE; sh/sb go to READ.
  - On accept with an illegal op, goes to RESP with err set.
  - Illegal = op 11, sw with addr[1:0]!=0, or sh with addr[0]=1.
- READ:
  - mem_req=1, mem_we=0, mem_be=0.
  - On mem_ack, capture mem_rdata into the merge register and go to WRITE.
- WRITE:
  - mem_req=1, mem_we=1, mem_wdata = merged word.
  - On mem_ack, go to RESP.
- RESP:
  - done=1 for exactly one cycle; err=1 in the same cycle if rejected.
  - Always goes to IDLE next.
  - req_ready=0 in RESP, so back-to-back accept happens the cycle after done.
- Merge, little-endian:
  - sw: mem_wdata = wdata.
  - sh: addr[1]=0 replaces bits 15:0 with wdata[15:0]; addr[1]=1 replaces bits 31:16.
  - sb: lane addr[1:0] replaced with wdata[7:0].
  - All other bits come from the captured read word.
- mem_be in WRITE:
  - sw: 1111.
  - sh: 0011 or 1100.
  - sb: one-hot on addr[1:0].
- mem_addr is driven from the latched address in READ and WRITE. Request signals are stable while mem_req=1 and mem_ack=0 (wait states).
- Latency with zero-wait memory (ack in the same cycle), accept at edge T:
  - sw: WRITE in cycle T+1, done in T+2.
  - sh/sb: READ in T+1, WRITE in T+2, done in T+3.
  - Rejected request: done+err in T+1, no mem_req.

Optional Feature:
- Macro: STORE_MERGE_BE_EN.
- Defined:
  - Memory honours mem_be, so sh/sb skip READ and go IDLE to WRITE.
  - mem_wdata replicates data across lanes: sh gives {wdata[15:0], wdata[15:0]}; sb gives {4{wdata[7:0]}}.
  - mem_be carries the lane mask.
  - sh/sb latency equals sw.
- Undefined:
  - Read-modify-write as above; mem_be is still driven per lane but memory may ignore it.
  - mem_wdata always carries the full merged word.

Test Plan:
- Reset: hold reset=0 two cycles mid-WRITE with mem_ack=0, release → mem_req=0, done=0, req_ready=1, memory word unchanged.
- sw: addr=0x0000_0008, wdata=0xDEADBEEF, zero-wait → one write with mem_addr=2, mem_wdata=0xDEADBEEF, mem_be=1111, done at T+2.
- sb RMW:
  - Stimulus: mem word 3 = 0x11223344; sb addr=0x0000_000E, wdata=0xFFFFFFAB.
  - Macro undefined → read, then write mem_wdata=0x11AB3344, mem_be=0100, done at T+3.
  - Macro defined → single write, mem_wdata=0xABABABAB, mem_be=0100, done at T+2.
- sh high half, with 2 wait cycles per access: word 0 = 0xAAAA5555; sh addr=0x2, wdata=0x00001234 → write 0x12345555, mem_be=1100, request signals stable through the waits.
- Misaligned: sw addr=0x5, then sh addr=0x3, then st_op=11 → each gives done=1 and err=1 at T+1 with no mem_req.
- Back-to-back: req_valid held high with two sw requests → second accepted the cycle after the first done; req_ready=0 in READ/WRITE/RESP.
